// File: rtl/lod_pkg.sv
// Shared constants and result type for the log2 leading-one detector.
// Latency: none (package only).
// Backpressure: none (package only).
//
// LOD_WIDTH / LOD_LOG2_WIDTH are the default operand width and index width.
// LOD_LATENCY is the accept-to-out_valid latency of log2_lod_pipe when it is not stalled.
// lod_result_t is sized for the widest legal operand (16 bits). Narrower builds use its low bits.
package lod_pkg;

    localparam int LOD_WIDTH      = 16;
    localparam int LOD_LOG2_WIDTH = 4;
    localparam int LOD_LATENCY    = 2;

    typedef struct packed {
        logic [LOD_LOG2_WIDTH-1:0] k;
        logic                      zero;
        logic [LOD_WIDTH-1:0]      frac;
    } lod_result_t;

endpackage

// File: rtl/lod_half_enc.sv
// First-one (most-significant set bit) encoder over half of the operand.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   data - half-operand, HALF_WIDTH bits.
//   idx  - index of the highest set bit. It is 0 when data is 0.
//   nz   - high when any bit of data is set.
module lod_half_enc
    import lod_pkg::*;
#(
    parameter int HALF_WIDTH = LOD_WIDTH / 2,
    parameter int IDX_WIDTH  = LOD_LOG2_WIDTH - 1
) (
    input  logic [HALF_WIDTH-1:0] data,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  nz
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        idx = '0;
        for (int i = 0; i < HALF_WIDTH; i++) begin
            if (data[i]) idx = IDX_WIDTH'(i);
        end
    end

    assign nz = |data;

endmodule

// File: rtl/log2_lod_pipe.sv
// Two-stage pipelined leading-one detector: out_k = floor(log2(in_data)), out_frac = residual.
// Latency: 2 cycles from accept to out_valid when not stalled. Throughput is one result per cycle.
// Backpressure: valid/ready. Stages advance only into free slots, and in_ready = s1_en.
//
// Ports:
//   clk, rst                      - clock; synchronous active-high reset.
//   in_valid, in_ready, in_data   - operand handshake.
//   out_valid, out_ready          - result handshake.
//   out_k, out_zero, out_frac     - result outputs.
//
// Macro LOD_RESIDUAL_EN enables out_frac.
// When LOD_RESIDUAL_EN is undefined, out_frac reads 0 and the operand is not carried into S1.
module log2_lod_pipe
    import lod_pkg::*;
#(
    parameter int WIDTH      = LOD_WIDTH,
    parameter int LOG2_WIDTH = LOD_LOG2_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOG2_WIDTH-1:0] out_k,
    output logic                  out_zero,
    output logic [WIDTH-1:0]      out_frac
);

    localparam int HALF = WIDTH / 2;
    localparam int IW   = LOG2_WIDTH - 1;

    logic          hi_nz, lo_nz;
    logic [IW-1:0] hi_idx, lo_idx;

    lod_half_enc #(.HALF_WIDTH(HALF), .IDX_WIDTH(IW)) u_enc_hi (
        .data (in_data[WIDTH-1:HALF]),
        .idx  (hi_idx),
        .nz   (hi_nz)
    );

    lod_half_enc #(.HALF_WIDTH(HALF), .IDX_WIDTH(IW)) u_enc_lo (
        .data (in_data[HALF-1:0]),
        .idx  (lo_idx),
        .nz   (lo_nz)
    );

    // S1 state
    logic          s1_valid;
    logic          s1_hi_nz, s1_lo_nz;
    logic [IW-1:0] s1_hi_idx, s1_lo_idx;
`ifdef LOD_RESIDUAL_EN
    logic [WIDTH-1:0] s1_data;
`endif

    // S2 state
    logic        s2_valid;
    lod_result_t s2_res, s2_next;

    logic s1_en, s2_en;
    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Half select: the high half wins whenever it has any set bit.
    // Its index then gains the top bit.
    logic [LOG2_WIDTH-1:0] k_sel;
    assign k_sel = s1_hi_nz ? {1'b1, s1_hi_idx} : {1'b0, s1_lo_idx};

    always_comb begin
        s2_next      = '0;
        s2_next.k    = LOD_LOG2_WIDTH'(k_sel);
        s2_next.zero = !s1_hi_nz && !s1_lo_nz;
`ifdef LOD_RESIDUAL_EN
        // Clearing bit k leaves in_data - 2**k.
        // For a zero operand k_sel is 0 and bit 0 is already clear, so frac stays 0.
        begin
            logic [WIDTH-1:0] frac_w;
            frac_w         = s1_data;
            frac_w[k_sel]  = 1'b0;
            s2_next.frac   = LOD_WIDTH'(frac_w);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_hi_nz  <= 1'b0;
            s1_lo_nz  <= 1'b0;
            s1_hi_idx <= '0;
            s1_lo_idx <= '0;
`ifdef LOD_RESIDUAL_EN
            s1_data   <= '0;
`endif
            s2_valid  <= 1'b0;
            s2_res    <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_hi_nz  <= hi_nz;
                    s1_lo_nz  <= lo_nz;
                    s1_hi_idx <= hi_idx;
                    s1_lo_idx <= lo_idx;
`ifdef LOD_RESIDUAL_EN
                    s1_data   <= in_data;
`endif
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_res <= s2_next;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_k     = s2_res.k[LOG2_WIDTH-1:0];
    assign out_zero  = s2_res.zero;
    assign out_frac  = s2_res.frac[WIDTH-1:0];

endmodule

// File: tb/tb_log2_lod_pipe.sv
module tb_log2_lod_pipe;

    localparam int W  = 16;
    localparam int LW = 4;
`ifdef LOD_RESIDUAL_EN
    localparam bit RES = 1'b1;
`else
    localparam bit RES = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [W-1:0]  in_data, out_frac;
    logic [LW-1:0] out_k;

    log2_lod_pipe #(.WIDTH(W), .LOG2_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_k     (out_k),
        .out_zero  (out_zero),
        .out_frac  (out_frac)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    int           k_log[$];

    logic          prev_stall = 1'b0;
    logic [LW-1:0] prev_k;
    logic [W-1:0]  prev_frac;
    logic          prev_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(log2(x)) by repeated halving; 0 for x==0
    function automatic int ref_k(input int x);
        int k;
        int v;
        k = 0;
        v = x;
        while (v > 1) begin
            v = v / 2;
            k++;
        end
        return k;
    endfunction

    function automatic int ref_frac(input int x);
        if (!RES || x == 0) return 0;
        return x - (1 << ref_k(x));
    endfunction

    // One clock cycle: drive inputs, then check the output side and record any accept
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        logic [W-1:0] x;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        if (prev_stall) begin
            chk("hold_vld",  out_valid, 1);
            chk("hold_k",    out_k,     prev_k);
            chk("hold_frac", out_frac,  prev_frac);
            chk("hold_zero", out_zero,  prev_zero);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                x = exp_q.pop_front();
                chk("k",    out_k,    ref_k(int'(x)));
                chk("zero", out_zero, (x == 0));
                chk("frac", out_frac, ref_frac(int'(x)));
                if (RES && x != 0) chk("roundtrip", (32'd1 << out_k) | out_frac, x);
                k_log.push_back(int'(out_k));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_k     = out_k;
        prev_frac  = out_frac;
        prev_zero  = out_zero;
        acc = v && in_ready;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycle(1'b0, '0, 1'b1, acc);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        cycle(1'b0, '0, 1'b1, acc);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] d,
                            input int ek, input int efr, input int ez);
        logic acc;
        cycle(1'b1, d, 1'b1, acc);
        chk({tag, "_acc"}, acc, 1);
        cycle(1'b0, '0, 1'b1, acc);
        chk({tag, "_lat1"}, out_valid, 0);
        cycle(1'b0, '0, 1'b1, acc);
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_k"},    out_k,     ek);
        chk({tag, "_frac"}, out_frac,  efr);
        chk({tag, "_zero"}, out_zero,  ez);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic v, r;
        logic [W-1:0] d;

        // Reset, with an operand offered that must not be accepted
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_k",         out_k,     0);
        chk("rst_frac",      out_frac,  0);
        chk("rst_zero",      out_zero,  0);
        chk("rst_in_ready",  in_ready,  1);
        repeat (3) begin
            cycle(1'b0, '0, 1'b1, acc);
            chk("rst_no_accept", out_valid, 0);
        end

        // Directed values with latency checks
        directed("one",  16'h0001, 0,  0,                   0);
        directed("b4",   16'h00B4, 7,  RES ? 32'h34 : 32'h0, 0);
        directed("msb",  16'h8000, 15, 0,                   0);
        directed("zero", 16'h0000, 0,  0,                   1);

        // Backpressure: two accepts fill the pipe, the third waits for out_ready
        k_log.delete();
        cycle(1'b1, 16'h0003, 1'b0, acc);
        chk("bp_acc0", acc, 1);
        cycle(1'b1, 16'h0100, 1'b0, acc);
        chk("bp_acc1", acc, 1);
        cycle(1'b1, 16'h7FFF, 1'b0, acc);
        chk("bp_full_in_ready", in_ready, 0);
        cycle(1'b1, 16'h7FFF, 1'b0, acc);
        chk("bp_full_in_ready2", in_ready, 0);
        cycle(1'b1, 16'h7FFF, 1'b1, acc);
        chk("bp_rise_in_ready", in_ready, 1);
        drain();
        chk("bp_count", k_log.size(), 3);
        if (k_log.size() == 3) begin
            chk("bp_k0", k_log[0], 1);
            chk("bp_k1", k_log[1], 8);
            chk("bp_k2", k_log[2], 14);
        end

        // Random stream with out_ready toggling about half the time
        repeat (600) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1) == 1;
            d = W'($urandom) >> $urandom_range(0, 16);
            cycle(v, d, r, acc);
        end
        drain();

        // Reset with two operands in flight
        cycle(1'b1, 16'h0F00, 1'b0, acc);
        cycle(1'b1, 16'h0003, 1'b0, acc);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hABCD;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        exp_q.delete();
        prev_stall = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready,  1);
        repeat (4) begin
            cycle(1'b0, '0, 1'b1, acc);
            chk("midrst_no_stale", out_valid, 0);
        end
        directed("post_rst", 16'h0040, 6, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
